// File: rtl/bp_be_mmu_cmd_queue.sv
// bp_be_mmu_cmd_queue: in-order MMU command FIFO with outstanding-request throttle and sticky protocol error.
//   clk_i, reset_i              : clock, async active-high reset
//   cmd_i, cmd_v_i, ready_o     : enqueue side from the mem pipe (ready_o = not full)
//   flush_i                     : drop every queued, unissued command
//   mmu_cmd_o/_v_o, mmu_cmd_ready_i : head command handshake to the MMU
//   mem_resp_v_i                : one response returned for an issued command
//   empty_o, outstanding_o, err_o : status (err_o sticky on overflow/underflow)
package bp_be_mmu_cmd_queue_pkg;
    typedef enum logic [1:0] {e_bp_inv_cfg, e_bp_default_cfg, e_bp_sv32_cfg} bp_params_e;

    function automatic int cfg_vaddr_width(input bp_params_e cfg);
        return (cfg == e_bp_sv32_cfg) ? 32 : 39;
    endfunction

    // op (4b) + virtual address + 64b store data
    function automatic int bp_be_mmu_cmd_width(input int vaddr_width);
        return 4 + vaddr_width + 64;
    endfunction
endpackage

module bp_be_mmu_cmd_queue
    import bp_be_mmu_cmd_queue_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int els_p = 2,
    parameter int max_outstanding_p = 4,
    localparam int mmu_cmd_width_lp = bp_be_mmu_cmd_width(cfg_vaddr_width(bp_params_p)),
    localparam int ow_lp = $clog2(max_outstanding_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [mmu_cmd_width_lp-1:0] cmd_i,
    input  logic                        cmd_v_i,
    output logic                        ready_o,
    input  logic                        flush_i,
    output logic [mmu_cmd_width_lp-1:0] mmu_cmd_o,
    output logic                        mmu_cmd_v_o,
    input  logic                        mmu_cmd_ready_i,
    input  logic                        mem_resp_v_i,
    output logic                        empty_o,
    output logic [ow_lp-1:0]            outstanding_o,
    output logic                        err_o
);
    localparam int pw_lp = $clog2(els_p);
    localparam int cw_lp = $clog2(els_p + 1);
    localparam logic [pw_lp-1:0] last_c = pw_lp'(els_p - 1);
    localparam logic [cw_lp-1:0] full_c = cw_lp'(els_p);
    localparam logic [ow_lp-1:0] max_c  = ow_lp'(max_outstanding_p);

    logic [mmu_cmd_width_lp-1:0] mem_q [els_p];
    logic [pw_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cw_lp-1:0] cnt_q, cnt_d;
    logic [ow_lp-1:0] outs_q, outs_d;
    logic             err_q, err_d;
    logic             full, empty, enq, deq;

    assign full          = cnt_q == full_c;
    assign empty         = cnt_q == '0;
    assign ready_o       = ~full;
    assign empty_o       = empty;
    assign mmu_cmd_v_o   = ~empty & (outs_q < max_c);
    assign mmu_cmd_o     = mem_q[rptr_q];
    assign outstanding_o = outs_q;
    assign err_o         = err_q;

    always_comb begin
        enq    = cmd_v_i & ~full & ~flush_i;
        deq    = mmu_cmd_v_o & mmu_cmd_ready_i;
        rptr_d = flush_i ? '0 : deq ? ((rptr_q == last_c) ? '0 : rptr_q + pw_lp'(1)) : rptr_q;
        wptr_d = flush_i ? '0 : enq ? ((wptr_q == last_c) ? '0 : wptr_q + pw_lp'(1)) : wptr_q;
        cnt_d  = flush_i ? '0 : cnt_q + cw_lp'(enq) - cw_lp'(deq);
        // An issue and a response in the same cycle cancel; a response with nothing outstanding never wraps the count.
        outs_d = (deq & ~mem_resp_v_i) ? outs_q + ow_lp'(1)
               : (~deq & mem_resp_v_i & (outs_q != '0)) ? outs_q - ow_lp'(1)
               : outs_q;
        // A command dropped by a flush is intentional, not an overflow.
        err_d  = err_q | (cmd_v_i & full & ~flush_i) | (mem_resp_v_i & (outs_q == '0));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            outs_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            outs_q <= outs_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= cmd_i;
    end
endmodule

// File: tb/tb_bp_be_mmu_cmd_queue.sv
// tb_bp_be_mmu_cmd_queue: directed self-checking bench for bp_be_mmu_cmd_queue (els_p=2, max_outstanding_p=4).
module tb_bp_be_mmu_cmd_queue;
    import bp_be_mmu_cmd_queue_pkg::*;

    localparam int W  = bp_be_mmu_cmd_width(cfg_vaddr_width(e_bp_inv_cfg));
    localparam int OW = $clog2(4 + 1);

    logic          clk_i = 1'b0;
    logic          reset_i, cmd_v_i, flush_i, mmu_cmd_ready_i, mem_resp_v_i;
    logic          ready_o, mmu_cmd_v_o, empty_o, err_o;
    logic [W-1:0]  cmd_i, mmu_cmd_o;
    logic [OW-1:0] outstanding_o;
    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  got [16];
    int            n_got;

    always #5 clk_i = ~clk_i;

    bp_be_mmu_cmd_queue #(.bp_params_p(e_bp_inv_cfg), .els_p(2), .max_outstanding_p(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .ready_o(ready_o),
        .flush_i(flush_i), .mmu_cmd_o(mmu_cmd_o), .mmu_cmd_v_o(mmu_cmd_v_o),
        .mmu_cmd_ready_i(mmu_cmd_ready_i), .mem_resp_v_i(mem_resp_v_i), .empty_o(empty_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        cmd_v_i = 0; cmd_i = '0; flush_i = 0; mmu_cmd_ready_i = 0; mem_resp_v_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1;
        #2;
        reset_i = 0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        cmd_v_i = 1; cmd_i = 'h11; step();
        cmd_i = 'h12; step();
        cmd_i = 'h13; step();
        cmd_v_i = 0;
        #1;
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL pre_reset_err got=%0b exp=1", err_o); end
        reset_i = 1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
        total++; if (mmu_cmd_v_o !== 1'b0) begin bad++; $display("FAIL reset_v got=%0b exp=0", mmu_cmd_v_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty_o); end
        total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL reset_outs got=%0d exp=0", outstanding_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_o); end
        #1;
        reset_i = 0;
        step();
    endtask

    task automatic test_in_order();
        do_reset();
        mmu_cmd_ready_i = 1;
        cmd_v_i = 1; cmd_i = 'hA; #2;
        total++; if (ready_o !== 1'b1 || mmu_cmd_v_o !== 1'b0) begin bad++; $display("FAIL order_c0 got ready=%0b v=%0b exp ready=1 v=0", ready_o, mmu_cmd_v_o); end
        step();
        cmd_i = 'hB; #2;
        total++; if (ready_o !== 1'b1 || mmu_cmd_v_o !== 1'b1 || mmu_cmd_o !== 'hA) begin bad++; $display("FAIL order_A got ready=%0b v=%0b cmd=%0h exp 1 1 a", ready_o, mmu_cmd_v_o, mmu_cmd_o); end
        step();
        cmd_i = 'hC; #2;
        total++; if (ready_o !== 1'b1 || mmu_cmd_v_o !== 1'b1 || mmu_cmd_o !== 'hB) begin bad++; $display("FAIL order_B got ready=%0b v=%0b cmd=%0h exp 1 1 b", ready_o, mmu_cmd_v_o, mmu_cmd_o); end
        step();
        cmd_v_i = 0; #2;
        total++; if (ready_o !== 1'b1 || mmu_cmd_v_o !== 1'b1 || mmu_cmd_o !== 'hC) begin bad++; $display("FAIL order_C got ready=%0b v=%0b cmd=%0h exp 1 1 c", ready_o, mmu_cmd_v_o, mmu_cmd_o); end
        step();
        #2;
        total++; if (empty_o !== 1'b1 || outstanding_o !== 3'd3 || mmu_cmd_v_o !== 1'b0) begin bad++; $display("FAIL order_end got empty=%0b outs=%0d v=%0b exp 1 3 0", empty_o, outstanding_o, mmu_cmd_v_o); end
    endtask

    task automatic test_full_wrap();
        int fed;
        logic [W-1:0] exp_q [7];
        exp_q = '{'h1, 'h2, 'h4, 'h5, 'h6, 'h7, 'h8};
        do_reset();
        cmd_v_i = 1; cmd_i = 'h1; step();
        cmd_i = 'h2; #2;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL full_ready1 got=%0b exp=1", ready_o); end
        step();
        cmd_i = 'h3; #2;
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL full_ready0 got=%0b exp=0", ready_o); end
        step();
        cmd_v_i = 0; #2;
        total++; if (err_o !== 1'b1 || mmu_cmd_o !== 'h1 || empty_o !== 1'b0) begin bad++; $display("FAIL overflow got err=%0b head=%0h empty=%0b exp 1 1 0", err_o, mmu_cmd_o, empty_o); end
        mmu_cmd_ready_i = 1; mem_resp_v_i = 1;
        fed = 0; n_got = 0;
        for (int c = 0; c < 15; c++) begin
            cmd_v_i = (fed < 5) && ready_o;
            cmd_i = W'(4 + fed);
            #2;
            if (mmu_cmd_v_o && n_got < 16) begin got[n_got] = mmu_cmd_o; n_got++; end
            if (cmd_v_i) fed++;
            step();
        end
        idle();
        total++; if (n_got !== 7) begin bad++; $display("FAIL wrap_count got=%0d exp=7", n_got); end
        for (int i = 0; i < 7; i++) begin
            total++; if (i >= n_got || got[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_order[%0d] got=%0h exp=%0h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_outstanding();
        int fed;
        do_reset();
        mmu_cmd_ready_i = 1;
        fed = 0; n_got = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_v_i = (fed < 6) && ready_o;
            cmd_i = W'(1 + fed);
            #2;
            if (mmu_cmd_v_o && n_got < 16) begin got[n_got] = mmu_cmd_o; n_got++; end
            if (cmd_v_i) fed++;
            step();
        end
        cmd_v_i = 0; #2;
        total++; if (n_got !== 4) begin bad++; $display("FAIL limit_issued got=%0d exp=4", n_got); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== W'(i + 1)) begin bad++; $display("FAIL limit_order[%0d] got=%0h exp=%0h", i, got[i], i + 1); end
        end
        total++; if (outstanding_o !== 3'd4 || mmu_cmd_v_o !== 1'b0) begin bad++; $display("FAIL limit_hold got outs=%0d v=%0b exp 4 0", outstanding_o, mmu_cmd_v_o); end
        total++; if (ready_o !== 1'b0 || mmu_cmd_o !== 'h5) begin bad++; $display("FAIL limit_queue got ready=%0b head=%0h exp 0 5", ready_o, mmu_cmd_o); end
        mem_resp_v_i = 1; step();
        mem_resp_v_i = 0; #2;
        total++; if (outstanding_o !== 3'd3 || mmu_cmd_v_o !== 1'b1 || mmu_cmd_o !== 'h5) begin bad++; $display("FAIL limit_release got outs=%0d v=%0b cmd=%0h exp 3 1 5", outstanding_o, mmu_cmd_v_o, mmu_cmd_o); end
        step(); #2;
        total++; if (outstanding_o !== 3'd4 || mmu_cmd_v_o !== 1'b0 || mmu_cmd_o !== 'h6) begin bad++; $display("FAIL limit_again got outs=%0d v=%0b head=%0h exp 4 0 6", outstanding_o, mmu_cmd_v_o, mmu_cmd_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL limit_err got=%0b exp=0", err_o); end
    endtask

    task automatic test_flush();
        do_reset();
        cmd_v_i = 1; cmd_i = 'hA; step();
        cmd_i = 'hB; mmu_cmd_ready_i = 1; step();
        cmd_i = 'hC; mmu_cmd_ready_i = 0; step();
        cmd_v_i = 0; #1;
        total++; if (outstanding_o !== 3'd1 || ready_o !== 1'b0 || mmu_cmd_o !== 'hB) begin bad++; $display("FAIL flush_pre got outs=%0d ready=%0b head=%0h exp 1 0 b", outstanding_o, ready_o, mmu_cmd_o); end
        cmd_v_i = 1; cmd_i = 'hD; flush_i = 1; step();
        cmd_v_i = 0; flush_i = 0; #2;
        total++; if (empty_o !== 1'b1 || outstanding_o !== 3'd1 || err_o !== 1'b0 || mmu_cmd_v_o !== 1'b0) begin bad++; $display("FAIL flush got empty=%0b outs=%0d err=%0b v=%0b exp 1 1 0 0", empty_o, outstanding_o, err_o, mmu_cmd_v_o); end
        step(); #2;
        total++; if (empty_o !== 1'b1 || ready_o !== 1'b1) begin bad++; $display("FAIL flush_drop got empty=%0b ready=%0b exp 1 1", empty_o, ready_o); end
    endtask

    task automatic test_underflow();
        do_reset();
        mem_resp_v_i = 1; step();
        mem_resp_v_i = 0; #2;
        total++; if (err_o !== 1'b1 || outstanding_o !== 3'd0) begin bad++; $display("FAIL underflow got err=%0b outs=%0d exp 1 0", err_o, outstanding_o); end
        mmu_cmd_ready_i = 1;
        cmd_v_i = 1; cmd_i = 'hA; step();
        cmd_i = 'hB; step();
        cmd_i = 'hC; step();
        cmd_v_i = 0; mem_resp_v_i = 1; #2;
        total++; if (outstanding_o !== 3'd2 || mmu_cmd_v_o !== 1'b1 || mmu_cmd_o !== 'hC) begin bad++; $display("FAIL simul_pre got outs=%0d v=%0b cmd=%0h exp 2 1 c", outstanding_o, mmu_cmd_v_o, mmu_cmd_o); end
        step();
        mem_resp_v_i = 0; #2;
        total++; if (outstanding_o !== 3'd2 || empty_o !== 1'b1 || err_o !== 1'b1) begin bad++; $display("FAIL simul got outs=%0d empty=%0b err=%0b exp 2 1 1", outstanding_o, empty_o, err_o); end
        mem_resp_v_i = 1; step();
        mem_resp_v_i = 0; #2;
        total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL resp_dec got=%0d exp=1", outstanding_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        mmu_cmd_ready_i = 1;
        cmd_v_i = 1; cmd_i = 'h1; step();
        cmd_i = 'h2; step();
        cmd_i = 'h3; step();
        cmd_i = 'h4; step();
        mmu_cmd_ready_i = 0; cmd_i = 'h5; step();
        cmd_v_i = 0; #1;
        total++; if (outstanding_o !== 3'd3 || empty_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL areset_pre got outs=%0d empty=%0b ready=%0b exp 3 0 0", outstanding_o, empty_o, ready_o); end
        #1; reset_i = 1; #1;
        total++; if (ready_o !== 1'b1 || mmu_cmd_v_o !== 1'b0 || empty_o !== 1'b1 || outstanding_o !== 3'd0 || err_o !== 1'b0) begin bad++; $display("FAIL areset got ready=%0b v=%0b empty=%0b outs=%0d err=%0b exp 1 0 1 0 0", ready_o, mmu_cmd_v_o, empty_o, outstanding_o, err_o); end
        #1; reset_i = 0;
        mmu_cmd_ready_i = 1;
        for (int c = 0; c < 3; c++) begin
            step(); #2;
            total++; if (mmu_cmd_v_o !== 1'b0 || empty_o !== 1'b1) begin bad++; $display("FAIL areset_stale[%0d] got v=%0b empty=%0b exp 0 1", c, mmu_cmd_v_o, empty_o); end
        end
        mem_resp_v_i = 1; step();
        mem_resp_v_i = 0; #2;
        total++; if (err_o !== 1'b1 || outstanding_o !== 3'd0) begin bad++; $display("FAIL areset_late_resp got err=%0b outs=%0d exp 1 0", err_o, outstanding_o); end
    endtask

    initial begin
        idle();
        reset_i = 1;
        #12;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_outstanding();
        test_flush();
        test_underflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
